// File: rtl/forward_control_pkg.sv
// Purpose: shared pipeline definitions for the EX operand-forwarding control.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package forward_control_pkg;

  // Register-address width carried in the stage records. The top-level
  // NB_REG parameter is expected to match this value.
  localparam int PKG_NB_REG = 5;

  // Operand-mux select encodings.
  localparam logic [1:0] SEL_REG   = 2'b00;  // register-file read data
  localparam logic [1:0] SEL_EXMEM = 2'b01;  // EX/MEM ALU result
  localparam logic [1:0] SEL_MEMWB = 2'b10;  // MEM/WB write-back data
  localparam logic [1:0] SEL_IMM   = 2'b11;  // immediate (operand B only)

  // One pipeline-stage record as seen by the forwarding logic.
  typedef struct packed {
    logic                  valid;
    logic [PKG_NB_REG-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } stage_rec_t;

  // A bubble: nothing valid, nothing written, nothing loaded.
  localparam stage_rec_t REC_BUBBLE = '0;

endpackage

// File: rtl/forward_control_fwd_match.sv
// Purpose: compares one ID source register against one in-flight stage record.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module fwd_match
  import forward_control_pkg::*;
(
  input  logic [PKG_NB_REG-1:0] i_src,
  input  logic                  i_src_used,
  input  logic                  i_rec_valid,
  input  logic                  i_rec_regwrite,
  input  logic [PKG_NB_REG-1:0] i_rec_rd,
  output logic                  o_match
);

  // r0 is hard-wired zero, so a producer targeting it never forwards.
  assign o_match = i_rec_valid & i_rec_regwrite & i_src_used &
                   (i_rec_rd != '0) & (i_rec_rd == i_src);

endmodule

// File: rtl/forward_control.sv
// Purpose: tracks EX/MEM/WB records, registers operand-forwarding selects, raises load-use stall.
// Latency: selects valid one clock after ID presentation; stall_o is combinational.
// Backpressure: enable_i=0 freezes all state; stall_o asks PC/IF-ID to hold and injects a bubble.
module forward_control
  import forward_control_pkg::*;
#(
  parameter int NB_REG = PKG_NB_REG,
  parameter int NB_SEL = 2
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [NB_REG-1:0] id_rs_i,
  input  logic [NB_REG-1:0] id_rt_i,
  input  logic              id_rs_used_i,
  input  logic              id_rt_used_i,
  input  logic [NB_REG-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              id_alusrc_imm_i,
  output logic [NB_SEL-1:0] fwd_a_sel_o,
  output logic [NB_SEL-1:0] fwd_b_sel_o,
  output logic              stall_o
);

  stage_rec_t r_ex;
  stage_rec_t r_mem;
  stage_rec_t r_wb;

  logic [NB_SEL-1:0] r_fwd_a_sel;
  logic [NB_SEL-1:0] r_fwd_b_sel;

  logic              w_rs_ex_match;
  logic              w_rs_mem_match;
  logic              w_rt_ex_match;
  logic              w_rt_mem_match;
  logic              w_stall;
  logic              w_bubble;
  stage_rec_t        w_id_rec;
  stage_rec_t        w_ex_nxt;
  logic [NB_SEL-1:0] w_fwd_a_nxt;
  logic [NB_SEL-1:0] w_fwd_b_nxt;

  // The WB record completes the in-flight picture but no current consumer
  // reads it; this reduction keeps it visibly intentional.
  logic w_wb_unused;
  assign w_wb_unused = ^r_wb;

  fwd_match u_rs_ex (
    .i_src          (id_rs_i),
    .i_src_used     (id_rs_used_i),
    .i_rec_valid    (r_ex.valid),
    .i_rec_regwrite (r_ex.regwrite),
    .i_rec_rd       (r_ex.rd),
    .o_match        (w_rs_ex_match)
  );

  fwd_match u_rs_mem (
    .i_src          (id_rs_i),
    .i_src_used     (id_rs_used_i),
    .i_rec_valid    (r_mem.valid),
    .i_rec_regwrite (r_mem.regwrite),
    .i_rec_rd       (r_mem.rd),
    .o_match        (w_rs_mem_match)
  );

  fwd_match u_rt_ex (
    .i_src          (id_rt_i),
    .i_src_used     (id_rt_used_i),
    .i_rec_valid    (r_ex.valid),
    .i_rec_regwrite (r_ex.regwrite),
    .i_rec_rd       (r_ex.rd),
    .o_match        (w_rt_ex_match)
  );

  fwd_match u_rt_mem (
    .i_src          (id_rt_i),
    .i_src_used     (id_rt_used_i),
    .i_rec_valid    (r_mem.valid),
    .i_rec_regwrite (r_mem.regwrite),
    .i_rec_rd       (r_mem.rd),
    .o_match        (w_rt_mem_match)
  );

  // Load-use hazard: a load now in EX produces data too late for the ID instruction.
  always_comb begin
    w_stall = 1'b0;
    if (r_ex.valid && r_ex.memread && (r_ex.rd != '0)) begin
      w_stall = (id_rs_used_i && (r_ex.rd == id_rs_i)) ||
                (id_rt_used_i && (r_ex.rd == id_rt_i));
    end
  end

  // Next EX record and next selects; EX-stage producer beats MEM-stage producer.
  always_comb begin
    w_bubble          = w_stall | flush_i | ~id_valid_i;
    w_id_rec          = REC_BUBBLE;
    w_id_rec.valid    = 1'b1;
    w_id_rec.rd       = id_rd_i;
    w_id_rec.regwrite = id_regwrite_i;
    w_id_rec.memread  = id_memread_i;
    w_ex_nxt          = w_bubble ? REC_BUBBLE : w_id_rec;

    w_fwd_a_nxt = NB_SEL'(SEL_REG);
    w_fwd_b_nxt = NB_SEL'(SEL_REG);
    if (!w_bubble) begin
      if (w_rs_ex_match) begin
        w_fwd_a_nxt = NB_SEL'(SEL_EXMEM);
      end else if (w_rs_mem_match) begin
        w_fwd_a_nxt = NB_SEL'(SEL_MEMWB);
      end

      if (id_alusrc_imm_i) begin
        w_fwd_b_nxt = NB_SEL'(SEL_IMM);
      end else if (w_rt_ex_match) begin
        w_fwd_b_nxt = NB_SEL'(SEL_EXMEM);
      end else if (w_rt_mem_match) begin
        w_fwd_b_nxt = NB_SEL'(SEL_MEMWB);
      end
    end
  end

  // Advance the stage records and the selects together when the pipeline moves.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_ex        <= REC_BUBBLE;
      r_mem       <= REC_BUBBLE;
      r_wb        <= REC_BUBBLE;
      r_fwd_a_sel <= NB_SEL'(SEL_REG);
      r_fwd_b_sel <= NB_SEL'(SEL_REG);
    end else if (enable_i) begin
      r_wb        <= r_mem;
      r_mem       <= r_ex;
      r_ex        <= w_ex_nxt;
      r_fwd_a_sel <= w_fwd_a_nxt;
      r_fwd_b_sel <= w_fwd_b_nxt;
    end
  end

  assign fwd_a_sel_o = r_fwd_a_sel;
  assign fwd_b_sel_o = r_fwd_b_sel;
  assign stall_o     = w_stall;

endmodule

// File: tb/tb_forward_control.sv
// Purpose: directed table-driven check of forwarding selects and load-use stall.
// Latency: one vector per clock; selects checked #1 after the edge, stall before it.
// Backpressure: exercises enable_i freeze, stall and flush bubbles, async reset mid-stall.
module tb_forward_control;

  logic       clock_i;
  logic       reset_i;
  logic       enable_i;
  logic       flush_i;
  logic       id_valid_i;
  logic [4:0] id_rs_i;
  logic [4:0] id_rt_i;
  logic       id_rs_used_i;
  logic       id_rt_used_i;
  logic [4:0] id_rd_i;
  logic       id_regwrite_i;
  logic       id_memread_i;
  logic       id_alusrc_imm_i;
  logic [1:0] fwd_a_sel_o;
  logic [1:0] fwd_b_sel_o;
  logic       stall_o;

  int checks;
  int failures;

  forward_control #(.NB_REG(5), .NB_SEL(2)) dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .enable_i        (enable_i),
    .flush_i         (flush_i),
    .id_valid_i      (id_valid_i),
    .id_rs_i         (id_rs_i),
    .id_rt_i         (id_rt_i),
    .id_rs_used_i    (id_rs_used_i),
    .id_rt_used_i    (id_rt_used_i),
    .id_rd_i         (id_rd_i),
    .id_regwrite_i   (id_regwrite_i),
    .id_memread_i    (id_memread_i),
    .id_alusrc_imm_i (id_alusrc_imm_i),
    .fwd_a_sel_o     (fwd_a_sel_o),
    .fwd_b_sel_o     (fwd_b_sel_o),
    .stall_o         (stall_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  typedef struct {
    bit         en;
    bit         fl;
    bit         vld;
    logic [4:0] rs;
    logic [4:0] rt;
    bit         ru;
    bit         tu;
    logic [4:0] rd;
    bit         rw;
    bit         mr;
    bit         imm;
    bit         exp_stall;
    logic [1:0] exp_a;
    logic [1:0] exp_b;
    string      name;
  } vec_t;

  localparam int NVEC = 32;
  vec_t tbl[NVEC];

  function automatic vec_t mk(bit en, bit fl, bit vld, int rs, int rt, bit ru, bit tu,
                              int rd, bit rw, bit mr, bit imm,
                              bit st, int a, int b, string name);
    vec_t v;
    v.en = en; v.fl = fl; v.vld = vld;
    v.rs = 5'(rs); v.rt = 5'(rt); v.ru = ru; v.tu = tu;
    v.rd = 5'(rd); v.rw = rw; v.mr = mr; v.imm = imm;
    v.exp_stall = st; v.exp_a = 2'(a); v.exp_b = 2'(b);
    v.name = name;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    enable_i        = v.en;
    flush_i         = v.fl;
    id_valid_i      = v.vld;
    id_rs_i         = v.rs;
    id_rt_i         = v.rt;
    id_rs_used_i    = v.ru;
    id_rt_used_i    = v.tu;
    id_rd_i         = v.rd;
    id_regwrite_i   = v.rw;
    id_memread_i    = v.mr;
    id_alusrc_imm_i = v.imm;
  endtask

  // Present one ID instruction: stall is checked before the edge, selects after it.
  task automatic apply(input vec_t v);
    @(negedge clock_i);
    drive(v);
    #1;
    check({v.name, ".stall"}, int'(stall_o), int'(v.exp_stall));
    @(posedge clock_i);
    #1;
    check({v.name, ".sel_a"}, int'(fwd_a_sel_o), int'(v.exp_a));
    check({v.name, ".sel_b"}, int'(fwd_b_sel_o), int'(v.exp_b));
  endtask

  initial begin
    vec_t idle;
    vec_t cons;
    checks   = 0;
    failures = 0;

    //             en fl vld rs  rt ru tu  rd rw mr imm  st a  b
    tbl[0]  = mk(1, 0, 1,  1,  2, 1, 1,  3, 1, 0, 0,  0, 0, 0, "add_r3");
    tbl[1]  = mk(1, 0, 1,  3,  1, 1, 1,  4, 1, 0, 0,  0, 1, 0, "ex_fwd_a");
    tbl[2]  = mk(1, 0, 1,  0,  0, 1, 1,  5, 1, 0, 0,  0, 0, 0, "add_r5");
    tbl[3]  = mk(1, 0, 1,  1,  2, 1, 1,  6, 1, 0, 0,  0, 0, 0, "unrelated");
    tbl[4]  = mk(1, 0, 1,  1,  5, 1, 1,  8, 1, 0, 0,  0, 0, 2, "mem_fwd_b");
    tbl[5]  = mk(1, 0, 1,  1,  2, 1, 1,  9, 1, 0, 0,  0, 0, 0, "add_r9");
    tbl[6]  = mk(1, 0, 1,  1,  2, 1, 1, 10, 1, 0, 0,  0, 0, 0, "unrelated2");
    tbl[7]  = mk(1, 0, 1,  9,  9, 1, 1, 11, 1, 0, 1,  0, 2, 3, "imm_b");
    tbl[8]  = mk(1, 0, 1,  1,  2, 1, 1,  0, 1, 0, 0,  0, 0, 0, "wr_r0");
    tbl[9]  = mk(1, 0, 1,  0,  0, 1, 1, 12, 1, 0, 0,  0, 0, 0, "rd_r0");
    tbl[10] = mk(1, 0, 1,  1,  2, 1, 0,  0, 1, 1, 0,  0, 0, 0, "lw_r0");
    tbl[11] = mk(1, 0, 1,  0,  2, 1, 1, 13, 1, 0, 0,  0, 0, 0, "use_r0_nostall");
    tbl[12] = mk(1, 0, 1,  1,  2, 1, 1,  7, 1, 0, 0,  0, 0, 0, "wr_r7a");
    tbl[13] = mk(1, 0, 1,  1,  2, 1, 1,  7, 1, 0, 0,  0, 0, 0, "wr_r7b");
    tbl[14] = mk(1, 0, 1,  7,  7, 1, 1, 14, 1, 0, 0,  0, 1, 1, "priority");
    tbl[15] = mk(1, 0, 1,  1,  0, 1, 0,  2, 1, 1, 0,  0, 0, 0, "lw_r2");
    tbl[16] = mk(1, 0, 1,  2,  3, 1, 1,  3, 1, 0, 0,  1, 0, 0, "load_use");
    tbl[17] = mk(1, 0, 1,  2,  3, 1, 1,  3, 1, 0, 0,  0, 2, 0, "post_stall");
    tbl[18] = mk(1, 0, 1,  3,  1, 1, 1, 16, 1, 0, 0,  0, 1, 0, "use_r3");
    tbl[19] = mk(0, 0, 1,  3, 16, 1, 1, 17, 1, 0, 0,  0, 1, 0, "freeze1");
    tbl[20] = mk(0, 0, 1,  3, 16, 1, 1, 17, 1, 0, 0,  0, 1, 0, "freeze2");
    tbl[21] = mk(0, 0, 1,  3, 16, 1, 1, 17, 1, 0, 0,  0, 1, 0, "freeze3");
    tbl[22] = mk(1, 0, 1,  3, 16, 1, 1, 17, 1, 0, 0,  0, 2, 1, "thaw");
    tbl[23] = mk(1, 0, 1,  1,  2, 1, 0, 20, 1, 1, 0,  0, 0, 0, "lw_r20");
    tbl[24] = mk(0, 0, 1, 20,  2, 1, 1, 22, 1, 0, 0,  1, 0, 0, "frozen_stall");
    tbl[25] = mk(1, 0, 1, 20,  2, 1, 1, 22, 1, 0, 0,  1, 0, 0, "stall2");
    tbl[26] = mk(1, 0, 1, 20,  2, 1, 1, 22, 1, 0, 0,  0, 2, 0, "post_stall2");
    tbl[27] = mk(1, 1, 1, 22,  2, 1, 1, 21, 1, 0, 0,  0, 0, 0, "flush");
    tbl[28] = mk(1, 0, 1, 21, 21, 1, 1, 24, 1, 0, 0,  0, 0, 0, "no_fwd_flushed");
    tbl[29] = mk(1, 0, 1,  1,  2, 1, 0, 23, 1, 1, 0,  0, 0, 0, "lw_r23");
    tbl[30] = mk(1, 1, 1, 23,  2, 1, 1, 26, 1, 0, 0,  1, 0, 0, "flush_stall");
    tbl[31] = mk(1, 0, 1, 23,  2, 1, 1, 26, 1, 0, 0,  0, 2, 0, "after_flush_stall");

    // Reset with an idle ID stage.
    idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
    drive(idle);
    reset_i = 1'b1;
    repeat (3) @(posedge clock_i);
    #1;
    check("reset.sel_a", int'(fwd_a_sel_o), 0);
    check("reset.sel_b", int'(fwd_b_sel_o), 0);
    check("reset.stall", int'(stall_o), 0);
    @(negedge clock_i);
    reset_i = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      apply(tbl[i]);
    end

    // Load r25 whose base reg r26 is forwarded from EX, then a dependent use that stalls.
    apply(mk(1, 0, 1, 26, 0, 1, 0, 25, 1, 1, 0, 0, 1, 0, "lw_r25"));
    cons = mk(1, 0, 1, 25, 0, 1, 0, 27, 1, 0, 0, 1, 0, 0, "rst_cons");
    @(negedge clock_i);
    drive(cons);
    #1;
    check("pre_reset.stall", int'(stall_o), 1);
    check("pre_reset.sel_a", int'(fwd_a_sel_o), 1);
    #1;
    reset_i = 1'b1;
    #1;
    check("async_reset.stall", int'(stall_o), 0);
    check("async_reset.sel_a", int'(fwd_a_sel_o), 0);
    check("async_reset.sel_b", int'(fwd_b_sel_o), 0);
    #1;
    reset_i = 1'b0;
    @(posedge clock_i);
    #1;
    check("post_reset.sel_a", int'(fwd_a_sel_o), 0);
    check("post_reset.sel_b", int'(fwd_b_sel_o), 0);
    check("post_reset.stall", int'(stall_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
